// File: rtl/vdc_pkg.sv
// Shared definitions for vehicle_dynamics_cc: gear codes, cruise states and
// the D/R shift-table RPM curve.
package vdc_pkg;

  localparam logic [3:0] GEAR_P = 4'd3;
  localparam logic [3:0] GEAR_R = 4'd6;
  localparam logic [3:0] GEAR_N = 4'd9;
  localparam logic [3:0] GEAR_D = 4'd12;

  typedef enum logic [1:0] {
    CC_OFF      = 2'd0,
    CC_HOLD     = 2'd1,
    CC_OVERRIDE = 2'd2,
    CC_STANDBY  = 2'd3
  } cc_state_t;

  localparam int unsigned IDLE_RPM   = 800;
  localparam int unsigned RPM_MAX    = 8000;
  localparam int unsigned EFF_SLOPE  = 20;
  localparam int unsigned LIMP_SPEED = 60;
  localparam int unsigned LIMP_TEMP  = 180;

  localparam int unsigned BP_1 = 30;
  localparam int unsigned BP_2 = 60;
  localparam int unsigned BP_3 = 90;
  localparam int unsigned BP_4 = 130;
  localparam int unsigned BP_5 = 180;

  localparam int unsigned BASE_0 = 800;
  localparam int unsigned BASE_1 = 1500;
  localparam int unsigned BASE_2 = 1500;
  localparam int unsigned BASE_3 = 1600;
  localparam int unsigned BASE_4 = 1700;
  localparam int unsigned BASE_5 = 1800;

  localparam int unsigned SLOPE_0 = 90;
  localparam int unsigned SLOPE_1 = 70;
  localparam int unsigned SLOPE_2 = 50;
  localparam int unsigned SLOPE_3 = 40;
  localparam int unsigned SLOPE_4 = 30;
  localparam int unsigned SLOPE_5 = 20;

  function automatic int unsigned shift_rpm(input int unsigned s);
    if (s < BP_1)      return BASE_0 + s * SLOPE_0;
    else if (s < BP_2) return BASE_1 + (s - BP_1) * SLOPE_1;
    else if (s < BP_3) return BASE_2 + (s - BP_2) * SLOPE_2;
    else if (s < BP_4) return BASE_3 + (s - BP_3) * SLOPE_3;
    else if (s < BP_5) return BASE_4 + (s - BP_4) * SLOPE_4;
    else               return BASE_5 + (s - BP_5) * SLOPE_5;
  endfunction

endpackage

// File: rtl/vehicle_dynamics_cc_rpm_map.sv
// Registered RPM lookup: pedal-driven idle curve in P/N, shift table in D/R,
// saturated at RPM_MAX.
module vdc_rpm_map
  import vdc_pkg::*;
#(
  parameter int unsigned SPEED_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               engine_on,
  input  logic [SPEED_W-1:0] speed,
  input  logic [7:0]         eff,
  input  logic [3:0]         gear,
  output logic [13:0]        rpm
);

  int unsigned raw;
  logic [13:0] rpm_next;

  always_comb begin
    if (gear == GEAR_D || gear == GEAR_R)
      raw = shift_rpm(32'(speed));
    else
      raw = IDLE_RPM + 32'(eff) * EFF_SLOPE;
    rpm_next = (raw > RPM_MAX) ? 14'(RPM_MAX) : 14'(raw);
  end

  always_ff @(posedge clk) begin
    if (rst || !engine_on) rpm <= '0;
    else                   rpm <= rpm_next;
  end

endmodule

// File: rtl/vehicle_dynamics_cc.sv
// Vehicle physics core with cruise control FSM and OBD counters.
// Define VDC_LIMP_MODE_EN to cap speed at 60 and drop cruise to STANDBY when hot.
module vehicle_dynamics_cc
  import vdc_pkg::*;
#(
  parameter int unsigned SPEED_W       = 8,
  parameter int unsigned MAX_SPEED     = 250,
  parameter int unsigned MAX_REV_SPEED = 50,
  parameter int unsigned DEAD_ZONE     = 50,
  parameter int unsigned CC_MIN_SPEED  = 30,
  parameter int unsigned ESS_SPEED     = 50,
  parameter int unsigned FUEL_DIV      = 3,
  parameter int unsigned ODO_DIV       = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               engine_on,
  input  logic               tick_1sec,
  input  logic               tick_speed,
  input  logic [3:0]         current_gear,
  input  logic [7:0]         adc_accel,
  input  logic               is_brake_normal,
  input  logic               is_brake_hard,
  input  logic               cc_set,
  input  logic               cc_resume,
  input  logic               cc_cancel,
  output logic [SPEED_W-1:0] speed,
  output logic [13:0]        rpm,
  output logic [7:0]         fuel,
  output logic [7:0]         temp,
  output logic [31:0]        odometer_raw,
  output logic               ess_trigger,
  output logic [1:0]         cc_state,
  output logic [SPEED_W-1:0] cc_target
);

  localparam int unsigned RW      = SPEED_W + 2;
  localparam int unsigned DW      = ((RW > 8) ? RW : 8) + 1;
  localparam int unsigned FUEL_TW = (FUEL_DIV > 1) ? $clog2(FUEL_DIV) : 1;
  localparam int unsigned ODO_TW  = (ODO_DIV > 1) ? $clog2(ODO_DIV) : 1;

  cc_state_t             state_q, state_d;
  logic [SPEED_W-1:0]    speed_q, target_q, target_d;
  logic                  ess_q, ess_d;
  logic [7:0]            fuel_q, temp_q;
  logic [31:0]           odo_q;
  logic [FUEL_TW-1:0]    fuel_tmr;
  logic [ODO_TW-1:0]     odo_tmr;

  logic [7:0]            eff, power;
  logic [RW-1:0]         resistance, speed_w, spd_next, ceiling, inc;
  logic signed [DW-1:0]  d;
  logic                  brake, engage_ok, disengage, pwr_gt;

  assign eff        = (adc_accel > 8'(DEAD_ZONE)) ? adc_accel - 8'(DEAD_ZONE) : '0;
  assign power      = (current_gear == GEAR_D) ? eff :
                      (current_gear == GEAR_R) ? (eff >> 1) : '0;
  assign speed_w    = RW'(speed_q);
  assign resistance = speed_w + RW'(5);
  assign d          = $signed(DW'(power)) - $signed(DW'(resistance));
  assign pwr_gt     = (d > 0);

  assign brake      = is_brake_normal | is_brake_hard;
  assign engage_ok  = (current_gear == GEAR_D) && (speed_q >= SPEED_W'(CC_MIN_SPEED)) && !brake;
  assign disengage  = brake || cc_cancel || (current_gear != GEAR_D);

  always_comb begin
    ceiling = (current_gear == GEAR_R) ? RW'(MAX_REV_SPEED) : RW'(MAX_SPEED);
`ifdef VDC_LIMP_MODE_EN
    if (temp_q >= 8'(LIMP_TEMP) && ceiling > RW'(LIMP_SPEED)) ceiling = RW'(LIMP_SPEED);
`endif
  end

  // Brake beats cruise beats pedal; ess only re-evaluated on brake ticks.
  always_comb begin
    spd_next = speed_w;
    ess_d    = ess_q;
    inc      = '0;
    if (is_brake_hard) begin
      spd_next = (speed_w > RW'(8)) ? speed_w - RW'(8) : '0;
      ess_d    = (speed_w > RW'(ESS_SPEED));
    end else if (is_brake_normal) begin
      spd_next = (speed_w > RW'(3)) ? speed_w - RW'(3) : '0;
      ess_d    = 1'b0;
    end else if (state_q == CC_HOLD) begin
      if (speed_q < target_q)      spd_next = speed_w + RW'(1);
      else if (speed_q > target_q) spd_next = speed_w - RW'(1);
    end else if (d > 0) begin
      inc = (d > 50) ? RW'(3) : (d > 20) ? RW'(2) : RW'(1);
      if (speed_w < ceiling)
        spd_next = (speed_w + inc > ceiling) ? ceiling : speed_w + inc;
    end else if (d < 0) begin
      if (speed_w != '0) spd_next = speed_w - RW'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    case (state_q)
      CC_OFF, CC_STANDBY: begin
        if (cc_set && !cc_cancel && engage_ok) begin
          state_d  = CC_HOLD;
          target_d = speed_q;
        end else if (state_q == CC_STANDBY && cc_resume && !cc_cancel &&
                     engage_ok && target_q != '0) begin
          state_d = CC_HOLD;
        end
      end
      CC_HOLD: begin
        if (disengage)   state_d = CC_STANDBY;
        else if (pwr_gt) state_d = CC_OVERRIDE;
      end
      CC_OVERRIDE: begin
        if (disengage)    state_d = CC_STANDBY;
        else if (!pwr_gt) state_d = CC_HOLD;
      end
      default: state_d = CC_OFF;
    endcase
`ifdef VDC_LIMP_MODE_EN
    if (temp_q >= 8'(LIMP_TEMP) && state_d == CC_HOLD) begin
      state_d  = CC_STANDBY;
      target_d = target_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= CC_OFF;
      target_q <= '0;
      speed_q  <= '0;
      ess_q    <= 1'b0;
    end else if (!engine_on) begin
      state_q  <= CC_OFF;
      speed_q  <= '0;
      ess_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      if (tick_speed) begin
        speed_q <= SPEED_W'(spd_next);
        ess_q   <= ess_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fuel_q   <= 8'd100;
      temp_q   <= 8'd40;
      odo_q    <= '0;
      fuel_tmr <= '0;
      odo_tmr  <= '0;
    end else if (engine_on && tick_1sec) begin
      if (odo_tmr == ODO_TW'(ODO_DIV - 1)) begin
        odo_tmr <= '0;
        odo_q   <= odo_q + 32'(speed_q);
      end else begin
        odo_tmr <= odo_tmr + 1'b1;
      end
      if (speed_q != '0 || rpm > 14'd1000) begin
        if (fuel_tmr == FUEL_TW'(FUEL_DIV - 1)) begin
          fuel_tmr <= '0;
          if (fuel_q != '0) fuel_q <= fuel_q - 8'd1;
        end else begin
          fuel_tmr <= fuel_tmr + 1'b1;
        end
      end
      if (rpm > 14'd3000 && temp_q < 8'd200) temp_q <= temp_q + 8'd2;
      else if (temp_q > 8'd40)               temp_q <= temp_q - 8'd1;
    end
  end

  vdc_rpm_map #(.SPEED_W(SPEED_W)) u_rpm_map (
    .clk       (clk),
    .rst       (rst),
    .engine_on (engine_on),
    .speed     (speed_q),
    .eff       (eff),
    .gear      (current_gear),
    .rpm       (rpm)
  );

  assign speed        = speed_q;
  assign fuel         = fuel_q;
  assign temp         = temp_q;
  assign odometer_raw = odo_q;
  assign ess_trigger  = ess_q;
  assign cc_state     = state_q;
  assign cc_target    = target_q;

endmodule

// File: tb/tb_vehicle_dynamics_cc.sv
// Directed self-checking bench for vehicle_dynamics_cc; expected values are
// worked out by hand from the physics rules and shift table.
module tb_vehicle_dynamics_cc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        engine_on = 1'b0;
  logic        tick_1sec = 1'b0;
  logic        tick_speed = 1'b0;
  logic [3:0]  current_gear = 4'd3;
  logic [7:0]  adc_accel = 8'd0;
  logic        is_brake_normal = 1'b0;
  logic        is_brake_hard = 1'b0;
  logic        cc_set = 1'b0;
  logic        cc_resume = 1'b0;
  logic        cc_cancel = 1'b0;
  logic [7:0]  speed;
  logic [13:0] rpm;
  logic [7:0]  fuel, temp;
  logic [31:0] odometer_raw;
  logic        ess_trigger;
  logic [1:0]  cc_state;
  logic [7:0]  cc_target;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vehicle_dynamics_cc #(
    .SPEED_W(8), .MAX_SPEED(250), .MAX_REV_SPEED(50), .DEAD_ZONE(50),
    .CC_MIN_SPEED(30), .ESS_SPEED(50), .FUEL_DIV(3), .ODO_DIV(10)
  ) dut (
    .clk(clk), .rst(rst), .engine_on(engine_on), .tick_1sec(tick_1sec),
    .tick_speed(tick_speed), .current_gear(current_gear), .adc_accel(adc_accel),
    .is_brake_normal(is_brake_normal), .is_brake_hard(is_brake_hard),
    .cc_set(cc_set), .cc_resume(cc_resume), .cc_cancel(cc_cancel),
    .speed(speed), .rpm(rpm), .fuel(fuel), .temp(temp),
    .odometer_raw(odometer_raw), .ess_trigger(ess_trigger),
    .cc_state(cc_state), .cc_target(cc_target)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_speed = 1'b1; step(); tick_speed = 1'b0; step();
    end
  endtask

  task automatic secs(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1sec = 1'b1; step(); tick_1sec = 1'b0; step();
    end
  endtask

  task automatic brake_tick(input logic hard);
    is_brake_hard = hard; is_brake_normal = ~hard; tick_speed = 1'b1;
    step();
    is_brake_hard = 1'b0; is_brake_normal = 1'b0; tick_speed = 1'b0;
    step();
  endtask

  task automatic do_reset(input logic [3:0] gear, input logic [7:0] adc);
    current_gear = gear; adc_accel = adc;
    rst = 1'b1; step(); rst = 1'b0; engine_on = 1'b1; step();
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_speed"}, 32'(speed), 0);
    check({pfx, "_rpm"},   32'(rpm), 0);
    check({pfx, "_fuel"},  32'(fuel), 100);
    check({pfx, "_temp"},  32'(temp), 40);
    check({pfx, "_odo"},   odometer_raw, 0);
    check({pfx, "_ess"},   32'(ess_trigger), 0);
    check({pfx, "_cc"},    32'(cc_state), 0);
    check({pfx, "_tgt"},   32'(cc_target), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    // Reset values (engine still off after rst deasserts does not matter here)
    rst = 1'b1; step();
    check_reset_state("rst");
    rst = 1'b0;

    // D, adc=200: +3 to 30 after 10 ticks, 96 after 32, 126 after 47, settle 145
    do_reset(4'd12, 8'd200);
    ticks(10);
    check("accel_10", 32'(speed), 30);
    check("rpm_30", 32'(rpm), 1500);
    ticks(22);
    check("accel_32", 32'(speed), 96);
    check("rpm_96", 32'(rpm), 1840);
    ticks(15);
    check("accel_47", 32'(speed), 126);
    check("rpm_126", 32'(rpm), 3040);
    ticks(23);
    check("settle_145", 32'(speed), 145);
    check("rpm_145", 32'(rpm), 2150);

    // Cruise: adc=135 settles at 80
    do_reset(4'd12, 8'd135);
    cc_set = 1'b1; step(); cc_set = 1'b0;
    check("set_below_min", 32'(cc_state), 0);
    ticks(50);
    check("cruise_pre", 32'(speed), 80);
    check("rpm_80", 32'(rpm), 2500);
    adc_accel = 8'd0; cc_set = 1'b1; step(); cc_set = 1'b0;
    check("cc_hold", 32'(cc_state), 1);
    check("cc_tgt80", 32'(cc_target), 80);
    ticks(100);
    check("hold_speed", 32'(speed), 80);
    adc_accel = 8'd255; step();
    check("override", 32'(cc_state), 2);
    ticks(2);
    check("override_spd", 32'(speed), 86);
    adc_accel = 8'd0; step();
    check("back_hold", 32'(cc_state), 1);
    ticks(10);
    check("back_80", 32'(speed), 80);
    brake_tick(1'b0);
    check("brake_spd", 32'(speed), 77);
    check("brake_stby", 32'(cc_state), 3);
    cc_resume = 1'b1; step(); cc_resume = 1'b0;
    check("resume", 32'(cc_state), 1);
    check("resume_tgt", 32'(cc_target), 80);
    ticks(5);
    check("resume_80", 32'(speed), 80);
    cc_cancel = 1'b1; step(); cc_cancel = 1'b0;
    check("cancel", 32'(cc_state), 3);
    ticks(2);
    check("coast_78", 32'(speed), 78);
    cc_set = 1'b1; cc_cancel = 1'b1; step(); cc_set = 1'b0; cc_cancel = 1'b0;
    check("set_cancel_st", 32'(cc_state), 3);
    check("set_cancel_tgt", 32'(cc_target), 80);
    cc_set = 1'b1; step(); cc_set = 1'b0;
    check("reset_tgt", 32'(cc_target), 78);
    check("reset_hold", 32'(cc_state), 1);
    engine_on = 1'b0; step();
    check("off_speed", 32'(speed), 0);
    check("off_rpm", 32'(rpm), 0);
    check("off_cc", 32'(cc_state), 0);
    check("off_tgt", 32'(cc_target), 78);

    // Hard brake from 60
    do_reset(4'd12, 8'd135);
    ticks(25);
    check("hb_pre", 32'(speed), 60);
    adc_accel = 8'd0;
    brake_tick(1'b1);
    check("hb1_spd", 32'(speed), 52);
    check("hb1_ess", 32'(ess_trigger), 1);
    brake_tick(1'b1);
    check("hb2_spd", 32'(speed), 44);
    check("hb2_ess", 32'(ess_trigger), 1);
    brake_tick(1'b1);
    check("hb3_spd", 32'(speed), 36);
    check("hb3_ess", 32'(ess_trigger), 0);

    // Reverse ceiling, then reset mid-run
    do_reset(4'd6, 8'd255);
    ticks(30);
    check("rev_cap", 32'(speed), 50);
    check("rev_rpm", 32'(rpm), 2900);
    rst = 1'b1; step();
    check_reset_state("midrst");
    rst = 1'b0;

    // Fuel and odometer at speed 10
    do_reset(4'd12, 8'd65);
    ticks(10);
    check("odo_speed", 32'(speed), 10);
    secs(30);
    check("fuel_90", 32'(fuel), 90);
    check("odo_30", odometer_raw, 30);
    check("temp_40", 32'(temp), 40);

    // Parked, high pedal: rpm > 3000 heats the engine and burns fuel
    do_reset(4'd3, 8'd255);
    check("rpm_park", 32'(rpm), 4900);
    secs(5);
    check("temp_50", 32'(temp), 50);
    check("fuel_99", 32'(fuel), 99);
    check("odo_park", odometer_raw, 0);

`ifdef VDC_LIMP_MODE_EN
    secs(65);
    check("limp_temp", 32'(temp), 180);
    current_gear = 4'd12; step();
    ticks(40);
    check("limp_cap", 32'(speed), 60);
    cc_set = 1'b1; step(); cc_set = 1'b0;
    check("limp_cc", 32'(cc_state), 3);
    check("limp_tgt", 32'(cc_target), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vehicle_dynamics_cc.md
Name: vehicle_dynamics_cc

Overview:
- Parametrised next-generation vehicle physics core: speed integration, RPM, fuel, temperature and odometer.
- Adds a cruise-control state machine with set, resume and cancel, plus accelerator override.
- Sits between the gear selector / ADC / brake decoder and the dashboard, OBD and ESS lamp logic.

Parameters:
SPEED_W, 8, speed width; MAX_SPEED must fit in it.
MAX_SPEED, 250, forward speed ceiling (km/h).
MAX_REV_SPEED, 50, reverse speed ceiling.
DEAD_ZONE, 50, ADC counts subtracted from the accelerator reading.
CC_MIN_SPEED, 30, minimum speed at which cruise can engage.
ESS_SPEED, 50, hard-brake speed above which ess_trigger asserts.
FUEL_DIV, 3, tick_1sec ticks per fuel unit consumed.
ODO_DIV, 10, tick_1sec ticks per odometer accumulation.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
engine_on  in  1  engine running
tick_1sec  in  1  1 Hz single-cycle strobe
tick_speed  in  1  physics-update single-cycle strobe
current_gear  in  4  gear code: 3=P, 6=R, 9=N, 12=D
adc_accel  in  8  raw accelerator pedal value
is_brake_normal / is_brake_hard  in  1 each  brake levels
cc_set / cc_resume / cc_cancel  in  1 each  single-cycle cruise buttons
speed  out  SPEED_W  current speed
rpm  out  14  engine RPM, registered
fuel / temp  out  8 each  fuel level % / coolant temperature
odometer_raw  out  32  accumulated distance
ess_trigger  out  1  emergency stop signal
cc_state  out  2  cruise state
cc_target  out  SPEED_W  cruise target speed

Behaviour:
- Reset, sync, rst dominant: speed=0, rpm=0, fuel=100, temp=40, odometer=0, ess=0, cc_state=OFF, cc_target=0, all internal timers 0.
- engine_on=0: speed=0, rpm=0, ess=0, cc_state=OFF. cc_target, fuel, temp and odometer hold.
- eff = adc>DEAD_ZONE ? adc-DEAD_ZONE : 0.
- power = eff in D, eff>>1 in R, 0 otherwise. resistance = speed+5, computed SPEED_W+2 wide with no overflow.
- Speed is updated only on tick_speed. New speed is visible the next cycle. Priority is hard brake > normal brake > cruise HOLD > physics.
  - Hard brake: speed -= 8, saturating at 0. ess=1 if pre-update speed > ESS_SPEED, else 0.
  - Normal brake: speed -= 3, saturating at 0. ess=0.
  - HOLD: speed +1 if below cc_target, -1 if above, otherwise hold.
  - Physics, with d = power-resistance:
    - d>50: +3; d>20: +2; d>0: +1.
    - d<0: -1, floor 0. d=0: hold.
    - Clamp to MAX_SPEED. In R, no increase at or above MAX_REV_SPEED.
- Cruise FSM states: OFF=0, HOLD=1, OVERRIDE=2, STANDBY=3. Transitions are evaluated every clk.
  - OFF/STANDBY + cc_set, gear D, speed>=CC_MIN_SPEED, no brake: HOLD, cc_target<=speed.
  - STANDBY + cc_resume, same conditions, cc_target!=0: HOLD with target unchanged.
  - HOLD + power>resistance: OVERRIDE.
  - OVERRIDE + power<=resistance: HOLD.
  - HOLD/OVERRIDE + any brake, cc_cancel, or gear!=D: STANDBY.
  - Engine off: OFF.
  - Simultaneous cc_cancel and cc_set: cancel wins.
- RPM is registered and updated every clk from the current speed (1-cycle latency).
  - P/N: 800+eff*20.
  - D/R shift table: <30: 800+s*90; <60: 1500+(s-30)*70; <90: 1500+(s-60)*50; <130: 1600+(s-90)*40; <180: 1700+(s-130)*30; else 1800+(s-180)*20.
  - Saturate at 8000.
- OBD, updated on tick_1sec with engine_on:
  - Odometer: odo timer counts 0..ODO_DIV-1; on wrap, odometer += speed with 32-bit wrap.
  - Fuel: when speed>0 or rpm>1000, fuel timer counts 0..FUEL_DIV-1; on wrap, fuel -= 1, floor 0.
  - Temp: +2 when rpm>3000 and temp<200; else -1 when temp>40.

Optional Feature:
- Macro: VDC_LIMP_MODE_EN.
- Defined: when temp>=180, the speed ceiling becomes 60 and any increase above 60 is blocked. Cruise HOLD is forced to STANDBY, and the limp flag is visible as cc_state=STANDBY with cc_target unchanged.
- Undefined: no temperature-based limit, and the logic is absent.

Decomposition:
- Package vdc_pkg: gear codes (GEAR_P/R/N/D), cc_state enum, IDLE_RPM=800, RPM_MAX=8000, shift table breakpoints and slopes.
- Sub-module vdc_rpm_map: registered speed/eff/gear to RPM lookup. The FSM, physics and OBD stay in the top module.

Test Plan:
- D, adc=200, 60 tick_speed -> speed rises +3 then +2 then +1 and settles where power≈resistance (≈145). rpm matches table within 1 cycle.
- Speed 80, cc_set, adc=0 -> HOLD, target 80. Speed stays 80±1 for 100 ticks. adc=255 -> OVERRIDE. Release -> HOLD, speed back down to 80.
- HOLD at 80, is_brake_normal for 1 tick -> STANDBY, speed 77. cc_resume -> HOLD, speed climbs back to 80.
- Speed 60, is_brake_hard -> speed 52, ess=1. Next tick -> 44, ess=1. Next -> 36, ess=0.
- R, adc=255 -> speed stops at 50. rst asserted mid-run -> all outputs at reset values next cycle.
- engine_on, speed 10, 30 tick_1sec -> fuel 90, odometer +30. With VDC_LIMP_MODE_EN and temp forced to 180 -> speed capped at 60.
